// File: rtl/rx_word_buffer_pkg.sv
// Shared constants and helpers for the receive word buffer.
package rx_buf_pkg;

  localparam int RXB_WORD_W = 10;
  localparam logic [1:0] RXB_TAG_EOF = 2'b11;

  // Occupancy counter width: one extra bit so DEPTH itself is representable.
  function automatic int RXB_CNT_W(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/rx_word_buffer_if.sv
// Receiver-side capture, consumer handshake and status signals of rx_word_buffer.
interface rx_word_buffer_if import rx_buf_pkg::*; #(
  parameter int WORD_W = RXB_WORD_W,
  parameter int DEPTH  = 4
);

  localparam int CNT_W = RXB_CNT_W(DEPTH);

  logic              flush;
  logic              rx_done;
  logic [WORD_W-1:0] rx_data;
  logic              rx_enable;
  logic [WORD_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic              eof;

  modport master (
    output flush, rx_done, rx_data, out_ready,
    input  rx_enable, out_data, out_valid, count, overflow, eof
  );

  modport slave (
    input  flush, rx_done, rx_data, out_ready,
    output rx_enable, out_data, out_valid, count, overflow, eof
  );

endinterface

// File: rtl/rx_word_buffer_mem.sv
// DEPTH x WORD_W register array: one synchronous write port, asynchronous read.
module sync_fifo_mem #(
  parameter int WORD_W = 10,
  parameter int DEPTH  = 4,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/rx_word_buffer.sv
// Captures completed receiver words into a show-ahead FIFO with valid/ready output.
// Build option: define RX_WORD_BUFFER_EOF_EN to treat tag 2'b11 words as end-of-stream markers.
module rx_word_buffer import rx_buf_pkg::*; #(
  parameter int WORD_W = RXB_WORD_W,
  parameter int DEPTH  = 4
) (
  input  logic           clk,
  input  logic           rst,
  rx_word_buffer_if.slave bus
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = RXB_CNT_W(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic             done_q, done_d;
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             eof_q, eof_d;

  logic              push_req, full, empty, pop;
  logic              is_marker, accept, push_ok;
  logic [WORD_W-1:0] rdata;

  assign push_req = bus.rx_done & ~done_q;
  assign full     = (count_q == FULL_CNT);
  assign empty    = (count_q == '0);
  assign pop      = ~empty & bus.out_ready;

`ifdef RX_WORD_BUFFER_EOF_EN
  assign is_marker = (bus.rx_data[WORD_W-1 -: 2] == RXB_TAG_EOF);
`else
  assign is_marker = 1'b0;
`endif

  // Markers and post-eof words never reach the FIFO and never count as overflow.
  assign accept  = push_req & ~is_marker & ~eof_q;
  assign push_ok = accept & ~full;

  always_comb begin
    done_d     = bus.rx_done;
    wptr_d     = wptr_q + AW'(push_ok);
    rptr_d     = rptr_q + AW'(pop);
    count_d    = count_q + CNT_W'(push_ok) - CNT_W'(pop);
    overflow_d = overflow_q | (accept & full);
    eof_d      = eof_q | (push_req & is_marker);
    if (bus.flush) begin
      done_d     = 1'b0;
      wptr_d     = '0;
      rptr_d     = '0;
      count_d    = '0;
      overflow_d = 1'b0;
      eof_d      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      done_q     <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      eof_q      <= 1'b0;
    end else begin
      done_q     <= done_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      eof_q      <= eof_d;
    end
  end

  sync_fifo_mem #(
    .WORD_W (WORD_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push_ok & ~bus.flush & ~rst),
    .waddr (wptr_q),
    .wdata (bus.rx_data),
    .raddr (rptr_q),
    .rdata (rdata)
  );

  assign bus.rx_enable = ~full;
  assign bus.out_valid = ~empty;
  assign bus.out_data  = empty ? '0 : rdata;
  assign bus.count     = count_q;
  assign bus.overflow  = overflow_q;
  assign bus.eof       = eof_q;

endmodule

// File: tb/tb_rx_word_buffer.sv
// Directed table-driven bench for rx_word_buffer plus wrap, flush and end-of-stream sequences.
module tb_rx_word_buffer;

  logic clk;
  logic rst;

  rx_word_buffer_if #(.WORD_W(10), .DEPTH(4)) bus ();

  rx_word_buffer #(.WORD_W(10), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       done;
    logic [9:0] data;
    logic       rdy;
    logic       flush;
    logic       e_valid;
    logic [9:0] e_data;
    logic [2:0] e_cnt;
    logic       e_en;
    logic       e_ovf;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic add(input logic d, input logic [9:0] dat, input logic r, input logic f,
                     input logic ev, input logic [9:0] ed, input logic [2:0] ec,
                     input logic een, input logic eovf);
    vec_t v;
    v.done = d; v.data = dat; v.rdy = r; v.flush = f;
    v.e_valid = ev; v.e_data = ed; v.e_cnt = ec; v.e_en = een; v.e_ovf = eovf;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive inputs, let one rising edge pass, then sample after it settles.
  task automatic step(input logic d, input logic [9:0] dat, input logic r, input logic f);
    bus.rx_done   = d;
    bus.rx_data   = dat;
    bus.out_ready = r;
    bus.flush     = f;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic ev, input logic [9:0] ed,
                           input logic [2:0] ec, input logic een, input logic eovf);
    check({tag, ".valid"}, 32'(bus.out_valid), 32'(ev));
    check({tag, ".data"},  32'(bus.out_data),  32'(ed));
    check({tag, ".count"}, 32'(bus.count),     32'(ec));
    check({tag, ".enable"},32'(bus.rx_enable), 32'(een));
    check({tag, ".ovf"},   32'(bus.overflow),  32'(eovf));
  endtask

  initial begin
    rst = 1'b1;
    bus.rx_done = 1'b0; bus.rx_data = '0; bus.out_ready = 1'b0; bus.flush = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check_all("reset", 1'b0, 10'h000, 3'd0, 1'b1, 1'b0);
    check("reset.eof", 32'(bus.eof), 32'd0);
    rst = 1'b0;

    // Single word, level held five cycles, then popped; then a pop on empty.
    for (int i = 0; i < 5; i++) add(1, 10'h041, 0, 0, 1, 10'h041, 1, 1, 0);
    add(0, 10'h041, 0, 0, 1, 10'h041, 1, 1, 0);
    add(0, 10'h000, 1, 0, 0, 10'h000, 0, 1, 0);
    add(0, 10'h000, 1, 0, 0, 10'h000, 0, 1, 0);
    // Fill to four, fifth word overflows, drain in order.
    add(1, 10'h001, 0, 0, 1, 10'h001, 1, 1, 0); add(0, 10'h000, 0, 0, 1, 10'h001, 1, 1, 0);
    add(1, 10'h002, 0, 0, 1, 10'h001, 2, 1, 0); add(0, 10'h000, 0, 0, 1, 10'h001, 2, 1, 0);
    add(1, 10'h003, 0, 0, 1, 10'h001, 3, 1, 0); add(0, 10'h000, 0, 0, 1, 10'h001, 3, 1, 0);
    add(1, 10'h004, 0, 0, 1, 10'h001, 4, 0, 0); add(0, 10'h000, 0, 0, 1, 10'h001, 4, 0, 0);
    add(1, 10'h005, 0, 0, 1, 10'h001, 4, 0, 1); add(0, 10'h000, 0, 0, 1, 10'h001, 4, 0, 1);
    add(0, 10'h000, 1, 0, 1, 10'h002, 3, 1, 1);
    add(0, 10'h000, 1, 0, 1, 10'h003, 2, 1, 1);
    add(0, 10'h000, 1, 0, 1, 10'h004, 1, 1, 1);
    add(0, 10'h000, 1, 0, 0, 10'h000, 0, 1, 1);
    add(0, 10'h000, 0, 1, 0, 10'h000, 0, 1, 0);
    // Push+pop at count 2, then at count 4 (push dropped).
    add(1, 10'h011, 0, 0, 1, 10'h011, 1, 1, 0); add(0, 10'h000, 0, 0, 1, 10'h011, 1, 1, 0);
    add(1, 10'h012, 0, 0, 1, 10'h011, 2, 1, 0); add(0, 10'h000, 0, 0, 1, 10'h011, 2, 1, 0);
    add(1, 10'h013, 1, 0, 1, 10'h012, 2, 1, 0); add(0, 10'h000, 0, 0, 1, 10'h012, 2, 1, 0);
    add(1, 10'h014, 0, 0, 1, 10'h012, 3, 1, 0); add(0, 10'h000, 0, 0, 1, 10'h012, 3, 1, 0);
    add(1, 10'h015, 0, 0, 1, 10'h012, 4, 0, 0); add(0, 10'h000, 0, 0, 1, 10'h012, 4, 0, 0);
    add(1, 10'h016, 1, 0, 1, 10'h013, 3, 1, 1); add(0, 10'h000, 0, 0, 1, 10'h013, 3, 1, 1);
    // Flush with count 3 and overflow set.
    add(0, 10'h000, 0, 1, 0, 10'h000, 0, 1, 0);
    // rx_done held across a flush re-triggers one push afterwards.
    add(1, 10'h021, 0, 0, 1, 10'h021, 1, 1, 0);
    add(1, 10'h021, 0, 1, 0, 10'h000, 0, 1, 0);
    add(1, 10'h021, 0, 0, 1, 10'h021, 1, 1, 0);
    add(0, 10'h000, 1, 0, 0, 10'h000, 0, 1, 0);

    foreach (vecs[i]) begin
      step(vecs[i].done, vecs[i].data, vecs[i].rdy, vecs[i].flush);
      check_all($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_data,
                vecs[i].e_cnt, vecs[i].e_en, vecs[i].e_ovf);
    end

    // Wrap: ten words streamed through with the consumer always ready.
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 10'(10'h100 + i), 1'b1, 1'b0);
      check($sformatf("wrap%0d.valid", i), 32'(bus.out_valid), 32'd1);
      check($sformatf("wrap%0d.data", i),  32'(bus.out_data),  32'(10'h100 + i));
      step(1'b0, 10'h000, 1'b1, 1'b0);
      check($sformatf("wrap%0d.count", i), 32'(bus.count), 32'd0);
    end
    check("wrap.ovf", 32'(bus.overflow), 32'd0);

    // End-of-stream marker handling.
    step(1'b0, 10'h000, 1'b0, 1'b1);
    step(1'b1, 10'h0AA, 1'b0, 1'b0); step(1'b0, 10'h000, 1'b0, 1'b0);
    step(1'b1, 10'h300, 1'b0, 1'b0); step(1'b0, 10'h000, 1'b0, 1'b0);
    step(1'b1, 10'h0BB, 1'b0, 1'b0); step(1'b0, 10'h000, 1'b0, 1'b0);
`ifdef RX_WORD_BUFFER_EOF_EN
    check_all("eof", 1'b1, 10'h0AA, 3'd1, 1'b1, 1'b0);
    check("eof.flag", 32'(bus.eof), 32'd1);
    step(1'b0, 10'h000, 1'b0, 1'b1);
    check("eof.flush", 32'(bus.eof), 32'd0);
`else
    check_all("noeof", 1'b1, 10'h0AA, 3'd3, 1'b1, 1'b0);
    check("noeof.flag", 32'(bus.eof), 32'd0);
    step(1'b0, 10'h000, 1'b1, 1'b0);
    check("noeof.d1", 32'(bus.out_data), 32'h300);
    step(1'b0, 10'h000, 1'b1, 1'b0);
    check("noeof.d2", 32'(bus.out_data), 32'h0BB);
    step(1'b0, 10'h000, 1'b1, 1'b0);
    check("noeof.empty", 32'(bus.out_valid), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
